morse_sequencer: RTL
====================

Name: morse_sequencer

Overview:
Controller that plays a queued message of Morse letters on the existing letter-pattern datapath (3-bit letter select -> 13-bit pattern mux -> loadable left-shift register -> LED).
- Owns a small letter FIFO.
- For each letter: drives select, pulses the shift register's active-low load, gates shift enables from the rate-divider tick for one full pattern, then holds an inter-letter gap.
- Sits between the switch/key front end and the shift-register/rate-divider datapath.

Parameters:
DEPTH, 4, letter FIFO depth; power of two, >= 2.
SYMBOL_LEN, 13, shift enables issued per letter; equals pattern width.
GAP_TICKS, 3, ticks of forced-off gap after each letter; must be >= 1.

Ports:
clock  input  1  system clock (CLOCK_50 domain); all logic on posedge.
resetn  input  1  asynchronous active-low reset.
tick  input  1  one-cycle enable pulse from the rate divider.
push  input  1  write push_code into the FIFO this cycle.
push_code  input  3  letter select code to enqueue.
start  input  1  begin playback; level-sampled.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
sel  output  3  letter select to the pattern mux.
load_n  output  1  active-low parallel load to the shift register.
shift_en  output  1  shift enable to the shift register.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the message completes.

Behaviour:
- Async reset (resetn=0), immediately:
  - state=IDLE; FIFO emptied (pointers and count = 0).
  - sel=0, load_n=1, shift_en=0, busy=0, done=0, full=0, empty=1.
- Reset mid-playback discards the queued letters and the letter in flight. No done pulse.
- FIFO:
  - push accepted only when full=0 in that cycle; push while full is dropped silently, even if a pop occurs the same cycle.
  - Pop happens only in LOAD. Simultaneous accepted push and pop leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Pushes are allowed in every state, including during playback.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - load_n=1, shift_en=0.
  - start=1 and empty=0 -> LOAD.
  - start with empty=1 is ignored: no state change, no done.
- LOAD, exactly one cycle:
  - sel registered to the FIFO head code on entry and valid during LOAD.
  - load_n=0; FIFO pops at the end of the cycle.
  - tick in this cycle is ignored.
  - Next state SHIFT with bit counter=0.
- SHIFT:
  - shift_en = tick (combinational gate, same cycle as tick).
  - Each tick increments the bit counter.
  - tick while counter==SYMBOL_LEN-1 -> GAP with gap counter=0.
  - Exactly SYMBOL_LEN shift_en pulses per letter.
- GAP:
  - shift_en=0, load_n=1.
  - Each tick increments the gap counter.
  - tick while gap counter==GAP_TICKS-1: FIFO non-empty (including letters pushed during playback) -> LOAD; otherwise -> IDLE with done=1 for that single cycle of IDLE entry.
- sel holds the last loaded code in all states except reset. start is ignored outside IDLE.
- Counters are sized by clog2 of the parameter; no arithmetic overflow is reachable.
- Latency:
  - start -> load_n low: 1 cycle (LOAD entered at the next edge).
  - Per letter: 1 + SYMBOL_LEN + GAP_TICKS tick-spaced intervals.

Test Plan:
- Reset then push codes 3'b001, 3'b011, start pulse; tick every 4 cycles.
  - Two load_n pulses, sel=1 then 3.
  - 13 shift_en pulses after each load.
  - 3 silent ticks after each letter; done one cycle after the second gap; empty=1.
- Push 4 codes (DEPTH=4): full=1. Fifth push 3'b111 dropped. Play all: exactly 4 LOADs, sel sequence matches pushes in order.
- start with empty FIFO -> state stays IDLE, busy=0, no done, load_n stays 1.
- During SHIFT of letter 1 (only letter queued), push 3'b101 -> after GAP goes to LOAD (not IDLE), sel=5, single done at the very end.
- tick asserted in the LOAD cycle -> not counted: still 13 shift_en pulses. tick held high continuously -> shift_en high for exactly 13 consecutive cycles.
- resetn pulsed low mid-SHIFT with 2 letters queued -> outputs at reset values immediately, empty=1, no done; a later push+start plays normally.

Source files
------------

// File: rtl/morse_sequencer_if.sv
// Bundles the front-end and datapath signals of the Morse letter sequencer.
// The master side feeds letters and ticks; the slave side is the sequencer itself.
interface morse_sequencer_if;
    logic       tick;
    logic       push;
    logic [2:0] push_code;
    logic       start;
    logic       full;
    logic       empty;
    logic [2:0] sel;
    logic       load_n;
    logic       shift_en;
    logic       busy;
    logic       done;

    modport master (
        output tick, push, push_code, start,
        input  full, empty, sel, load_n, shift_en, busy, done
    );

    modport slave (
        input  tick, push, push_code, start,
        output full, empty, sel, load_n, shift_en, busy, done
    );
endinterface

// File: rtl/morse_sequencer.sv
// Plays a queue of Morse letters: loads each pattern, gates SYMBOL_LEN shifts
// from the rate-divider tick, then holds a GAP_TICKS silent gap.
module morse_sequencer #(
    parameter int DEPTH      = 4,
    parameter int SYMBOL_LEN = 13,
    parameter int GAP_TICKS  = 3
) (
    input  logic             clock,
    input  logic             resetn,
    morse_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(SYMBOL_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [BW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [2:0]      sel_reg;
    logic            done_reg, done_next;
    logic            full_w, empty_w, push_ok, pop_w;

    assign full_w  = (count_reg == CNT_FULL);
    assign empty_w = (count_reg == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot that cycle.
    assign push_ok = bus.push && !full_w;
    assign pop_w   = (state_reg == S_LOAD);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= bus.push_code;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_w})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= done_next;
        end
    end

    // LOAD only ever lasts one cycle, so entering it is simply state_next == LOAD.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_reg <= 3'd0;
        end else if (state_next == S_LOAD) begin
            sel_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        done_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start && !empty_w) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next   = S_SHIFT;
                bit_cnt_next = '0;
            end
            S_SHIFT: begin
                if (bus.tick) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next   = S_GAP;
                        gap_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (bus.tick) begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        if (!empty_w) begin
                            state_next = S_LOAD;
                        end else begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.sel      = sel_reg;
    assign bus.load_n   = (state_reg != S_LOAD);
    assign bus.shift_en = (state_reg == S_SHIFT) && bus.tick;
    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.done     = done_reg;
endmodule
